prng_p2s: RTL and testbench

Parallel-to-serial converter directly downstream of the PRNG core. It captures each 32-bit random word when the PRNG pulses `done`, double-buffers it in a holding register, and shifts it out one bit per bit-cell. It provides framing strobes and a `ready` status that the PRNG controller checks before issuing the next `start`.

---
 rtl/prng_pkg.sv | 23 ++
 rtl/prng_p2s_if.sv | 26 ++
 rtl/p2s_bitclk.sv | 55 +++++
 rtl/prng_p2s.sv | 145 ++++++++++++++
 tb/tb_prng_p2s.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/prng_pkg.sv
// Shared definitions for the PRNG core and its serial back-end.
// Holds the converter FSM encoding, default sizing and the Park-Miller constants.
package prng_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } p2s_state_t;

    localparam int PRNG_WIDTH          = 32;
    localparam int P2S_CLK_DIV_DEFAULT = 4;

    localparam logic [31:0] PM_MODULUS    = 32'h7FFF_FFFF;
    localparam logic [31:0] PM_MULTIPLIER = 32'd16807;

    // One Park-Miller step: s * 16807 mod (2^31 - 1).
    function automatic logic [31:0] pm_step(input logic [31:0] seed);
        logic [63:0] prod;
        prod = {32'd0, seed} * {32'd0, PM_MULTIPLIER};
        return 32'(prod % {32'd0, PM_MODULUS});
    endfunction

endpackage

// File: rtl/prng_p2s_if.sv
// Capture/serial bundle between the PRNG core (master) and the converter (slave).
interface prng_p2s_if import prng_pkg::*; #(
    parameter int WIDTH = PRNG_WIDTH
) ();

    logic             load;
    logic [WIDTH-1:0] din;
    logic             ready;
    logic             busy;
    logic             sout;
    logic             bit_stb;
    logic             frame;
    logic             word_done;
    logic             overflow;

    modport master (
        output load, din,
        input  ready, busy, sout, bit_stb, frame, word_done, overflow
    );

    modport slave (
        input  load, din,
        output ready, busy, sout, bit_stb, frame, word_done, overflow
    );

endinterface

// File: rtl/p2s_bitclk.sv
// Bit-cell timing for the serializer: divides clk into cells and counts cells per word.
// start (re)arms both counters; the pair stops by itself after the last cell.
module p2s_bitclk #(
    parameter int WIDTH   = 32,
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic cell_start,
    output logic last_cell_end,
    output logic first_cell
);

    localparam int BW = $clog2(WIDTH);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt_r;
    logic [BW-1:0] bit_cnt_r;
    logic          active_r;
    logic          wrap_s;
    logic          at_last_s;

    assign wrap_s        = active_r && (div_cnt_r == DIV_LAST);
    assign at_last_s     = (bit_cnt_r == BIT_LAST);
    assign cell_start    = wrap_s && !at_last_s;
    assign last_cell_end = wrap_s && at_last_s;
    assign first_cell    = active_r && (bit_cnt_r == {BW{1'b0}});

    // Divider and cell counter; both saturate at their terminal values by wrapping or stopping.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= {DW{1'b0}};
            bit_cnt_r <= {BW{1'b0}};
            active_r  <= 1'b0;
        end else if (start) begin
            div_cnt_r <= {DW{1'b0}};
            bit_cnt_r <= {BW{1'b0}};
            active_r  <= 1'b1;
        end else if (wrap_s) begin
            div_cnt_r <= {DW{1'b0}};
            if (at_last_s) begin
                bit_cnt_r <= {BW{1'b0}};
                active_r  <= 1'b0;
            end else begin
                bit_cnt_r <= bit_cnt_r + BW'(1);
            end
        end else if (active_r) begin
            div_cnt_r <= div_cnt_r + DW'(1);
        end
    end

endmodule

// File: rtl/prng_p2s.sv
// Double-buffered parallel-to-serial converter behind the PRNG core.
// A held word is moved into the shifter as soon as the shifter is free, giving gapless output.
module prng_p2s import prng_pkg::*; #(
    parameter int WIDTH     = PRNG_WIDTH,
    parameter int CLK_DIV   = P2S_CLK_DIV_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    prng_p2s_if.slave bus
);

    p2s_state_t       state_r, state_next_s;
    logic [WIDTH-1:0] hold_r, hold_next_s;
    logic [WIDTH-1:0] shifter_r, shifter_next_s;
    logic             hold_valid_r, hold_valid_next_s;
    logic             sout_r, sout_next_s;
    logic             bit_stb_r, bit_stb_next_s;
    logic             frame_r, frame_next_s;
    logic             word_done_r, word_done_next_s;
    logic             busy_r, busy_next_s;
    logic             ready_r;
    logic             overflow_r, overflow_next_s;
    logic             cell_start_s, last_cell_end_s, first_cell_s;
    logic             start_s, accept_s;

    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // Hand the held word to the shifter when idle or exactly as the last cell ends.
    assign start_s  = hold_valid_r && ((state_r == IDLE) || last_cell_end_s);
    assign accept_s = bus.load && !hold_valid_r;

    p2s_bitclk #(
        .WIDTH   (WIDTH),
        .CLK_DIV (CLK_DIV)
    ) u_bitclk (
        .clk           (clk),
        .rst           (rst),
        .start         (start_s),
        .cell_start    (cell_start_s),
        .last_cell_end (last_cell_end_s),
        .first_cell    (first_cell_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (hold_valid_r) state_next_s = SHIFT;
                else              state_next_s = IDLE;
            end
            SHIFT: begin
                if (last_cell_end_s && !hold_valid_r) state_next_s = IDLE;
                else                                  state_next_s = SHIFT;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Next values of the datapath and of every registered output.
    always_comb begin
        shifter_next_s = shifter_r;
        sout_next_s    = sout_r;
        if (start_s) begin
            shifter_next_s = hold_r;
            sout_next_s    = lead_bit(hold_r);
        end else if (cell_start_s) begin
            shifter_next_s = shift_word(shifter_r);
            sout_next_s    = lead_bit(shift_word(shifter_r));
        end else if (last_cell_end_s) begin
            sout_next_s    = 1'b0;
        end else begin
            sout_next_s    = sout_r;
        end

        if (accept_s) begin
            hold_next_s       = bus.din;
            hold_valid_next_s = 1'b1;
        end else if (start_s) begin
            hold_next_s       = hold_r;
            hold_valid_next_s = 1'b0;
        end else begin
            hold_next_s       = hold_r;
            hold_valid_next_s = hold_valid_r;
        end

        bit_stb_next_s   = start_s || cell_start_s;
        frame_next_s     = start_s || (first_cell_s && !cell_start_s);
        word_done_next_s = last_cell_end_s;
        busy_next_s      = (state_next_s == SHIFT);
        overflow_next_s  = overflow_r || (bus.load && hold_valid_r);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_r       <= {WIDTH{1'b0}};
            hold_valid_r <= 1'b0;
            shifter_r    <= {WIDTH{1'b0}};
            sout_r       <= 1'b0;
            bit_stb_r    <= 1'b0;
            frame_r      <= 1'b0;
            word_done_r  <= 1'b0;
            busy_r       <= 1'b0;
            ready_r      <= 1'b1;
            overflow_r   <= 1'b0;
        end else begin
            hold_r       <= hold_next_s;
            hold_valid_r <= hold_valid_next_s;
            shifter_r    <= shifter_next_s;
            sout_r       <= sout_next_s;
            bit_stb_r    <= bit_stb_next_s;
            frame_r      <= frame_next_s;
            word_done_r  <= word_done_next_s;
            busy_r       <= busy_next_s;
            ready_r      <= !hold_valid_next_s;
            overflow_r   <= overflow_next_s;
        end
    end

    assign bus.sout      = sout_r;
    assign bus.bit_stb   = bit_stb_r;
    assign bus.frame     = frame_r;
    assign bus.word_done = word_done_r;
    assign bus.busy      = busy_r;
    assign bus.ready     = ready_r;
    assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_prng_p2s.sv
// Directed bench for prng_p2s: three instances cover CLK_DIV 1/4/2 and both bit orders.
module tb_prng_p2s;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    prng_p2s_if #(.WIDTH(32)) if1 ();
    prng_p2s_if #(.WIDTH(32)) if4 ();
    prng_p2s_if #(.WIDTH(32)) if2 ();

    prng_p2s #(.WIDTH(32), .CLK_DIV(1), .MSB_FIRST(1'b1)) u1 (.clk(clk), .rst(rst), .bus(if1));
    prng_p2s #(.WIDTH(32), .CLK_DIV(4), .MSB_FIRST(1'b1)) u4 (.clk(clk), .rst(rst), .bus(if4));
    prng_p2s #(.WIDTH(32), .CLK_DIV(2), .MSB_FIRST(1'b0)) u2 (.clk(clk), .rst(rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++; if (if1.ready !== 1'b1)     begin n_fail++; $display("FAIL reset_ready got %b exp 1", if1.ready); end
        n_checks++; if (if1.busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b exp 0", if1.busy); end
        n_checks++; if (if1.sout !== 1'b0)      begin n_fail++; $display("FAIL reset_sout got %b exp 0", if1.sout); end
        n_checks++; if (if1.bit_stb !== 1'b0)   begin n_fail++; $display("FAIL reset_bit_stb got %b exp 0", if1.bit_stb); end
        n_checks++; if (if1.frame !== 1'b0)     begin n_fail++; $display("FAIL reset_frame got %b exp 0", if1.frame); end
        n_checks++; if (if1.word_done !== 1'b0) begin n_fail++; $display("FAIL reset_word_done got %b exp 0", if1.word_done); end
        n_checks++; if (if1.overflow !== 1'b0)  begin n_fail++; $display("FAIL reset_overflow got %b exp 0", if1.overflow); end
        n_checks++; if (if4.ready !== 1'b1 || if2.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_others got %b%b exp 11", if4.ready, if2.ready); end
        tick();
    endtask

    // CLK_DIV=1, MSB first, single word 0x8000_0001.
    task automatic test_single();
        logic [31:0] v;
        v = 32'h8000_0001;
        if1.load = 1'b1; if1.din = v;
        tick();
        if1.load = 1'b0; if1.din = 32'h0000_0000;
        n_checks++; if (if1.ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_held got %b exp 0", if1.ready); end
        tick();
        n_checks++; if (if1.ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_back got %b exp 1", if1.ready); end
        for (int c = 0; c < 32; c++) begin
            n_checks++; if (if1.sout !== v[31-c])       begin n_fail++; $display("FAIL single_sout c=%0d got %b exp %b", c, if1.sout, v[31-c]); end
            n_checks++; if (if1.frame !== (c == 0))     begin n_fail++; $display("FAIL single_frame c=%0d got %b exp %b", c, if1.frame, (c == 0)); end
            n_checks++; if (if1.bit_stb !== 1'b1)       begin n_fail++; $display("FAIL single_bit_stb c=%0d got %b exp 1", c, if1.bit_stb); end
            n_checks++; if (if1.word_done !== 1'b0)     begin n_fail++; $display("FAIL single_word_done_early c=%0d got %b exp 0", c, if1.word_done); end
            n_checks++; if (if1.busy !== 1'b1)          begin n_fail++; $display("FAIL single_busy c=%0d got %b exp 1", c, if1.busy); end
            tick();
        end
        n_checks++; if (if1.word_done !== 1'b1) begin n_fail++; $display("FAIL single_word_done got %b exp 1", if1.word_done); end
        n_checks++; if (if1.busy !== 1'b0)      begin n_fail++; $display("FAIL single_busy_end got %b exp 0", if1.busy); end
        n_checks++; if (if1.sout !== 1'b0)      begin n_fail++; $display("FAIL single_sout_end got %b exp 0", if1.sout); end
        tick();
        n_checks++; if (if1.word_done !== 1'b0) begin n_fail++; $display("FAIL single_word_done_pulse got %b exp 0", if1.word_done); end
    endtask

    // CLK_DIV=4: each bit held 4 cycles, strobe every 4th cycle.
    task automatic test_clkdiv4();
        logic [31:0] v;
        v = 32'hA5A5_A5A5;
        if4.load = 1'b1; if4.din = v;
        tick();
        if4.load = 1'b0;
        tick();
        for (int c = 0; c < 128; c++) begin
            n_checks++; if (if4.sout !== v[31-(c/4)])       begin n_fail++; $display("FAIL div4_sout c=%0d got %b exp %b", c, if4.sout, v[31-(c/4)]); end
            n_checks++; if (if4.bit_stb !== ((c % 4) == 0)) begin n_fail++; $display("FAIL div4_bit_stb c=%0d got %b exp %b", c, if4.bit_stb, ((c % 4) == 0)); end
            n_checks++; if (if4.frame !== (c < 4))          begin n_fail++; $display("FAIL div4_frame c=%0d got %b exp %b", c, if4.frame, (c < 4)); end
            n_checks++; if (if4.word_done !== 1'b0)         begin n_fail++; $display("FAIL div4_word_done_early c=%0d got %b exp 0", c, if4.word_done); end
            tick();
        end
        n_checks++; if (if4.word_done !== 1'b1) begin n_fail++; $display("FAIL div4_word_done got %b exp 1", if4.word_done); end
        n_checks++; if (if4.busy !== 1'b0)      begin n_fail++; $display("FAIL div4_busy_end got %b exp 0", if4.busy); end
        tick();
        n_checks++; if (if4.busy !== 1'b0)      begin n_fail++; $display("FAIL div4_busy_after got %b exp 0", if4.busy); end
        n_checks++; if (if4.word_done !== 1'b0) begin n_fail++; $display("FAIL div4_word_done_pulse got %b exp 0", if4.word_done); end
    endtask

    // Second word loaded while the first shifts: 64 contiguous bits.
    task automatic test_back_to_back();
        logic [63:0] s;
        int          n_done;
        int          n_frame;
        s = {32'h1234_5678, 32'h9ABC_DEF0};
        n_done = 0;
        n_frame = 0;
        if1.load = 1'b1; if1.din = s[63:32];
        tick();
        if1.load = 1'b0;
        tick();
        for (int c = 0; c < 64; c++) begin
            n_checks++; if (if1.sout !== s[63-c])   begin n_fail++; $display("FAIL b2b_sout c=%0d got %b exp %b", c, if1.sout, s[63-c]); end
            n_checks++; if (if1.bit_stb !== 1'b1)   begin n_fail++; $display("FAIL b2b_bit_stb c=%0d got %b exp 1", c, if1.bit_stb); end
            n_checks++; if (if1.word_done !== (c == 32)) begin n_fail++; $display("FAIL b2b_word_done c=%0d got %b exp %b", c, if1.word_done, (c == 32)); end
            n_checks++; if (if1.frame !== (c == 0 || c == 32)) begin n_fail++; $display("FAIL b2b_frame c=%0d got %b exp %b", c, if1.frame, (c == 0 || c == 32)); end
            if (if1.word_done === 1'b1) n_done++;
            if (if1.frame === 1'b1) n_frame++;
            if1.load = (c == 2);
            if1.din  = s[31:0];
            tick();
        end
        if1.load = 1'b0;
        if (if1.word_done === 1'b1) n_done++;
        n_checks++; if (n_done !== 2)            begin n_fail++; $display("FAIL b2b_done_count got %0d exp 2", n_done); end
        n_checks++; if (n_frame !== 2)           begin n_fail++; $display("FAIL b2b_frame_count got %0d exp 2", n_frame); end
        n_checks++; if (if1.busy !== 1'b0)       begin n_fail++; $display("FAIL b2b_busy_end got %b exp 0", if1.busy); end
        n_checks++; if (if1.overflow !== 1'b0)   begin n_fail++; $display("FAIL b2b_overflow got %b exp 0", if1.overflow); end
        tick();
    endtask

    // Third load while hold is full is dropped and sets the sticky flag.
    task automatic test_overflow();
        logic [63:0] s;
        s = {32'hDEAD_BEEF, 32'h0F0F_00FF};
        if1.load = 1'b1; if1.din = s[63:32];
        tick();
        if1.load = 1'b0;
        tick();
        for (int c = 0; c < 64; c++) begin
            n_checks++; if (if1.sout !== s[63-c]) begin n_fail++; $display("FAIL ovf_sout c=%0d got %b exp %b", c, if1.sout, s[63-c]); end
            n_checks++; if (if1.overflow !== (c >= 3)) begin n_fail++; $display("FAIL ovf_flag c=%0d got %b exp %b", c, if1.overflow, (c >= 3)); end
            if (c == 1 || c == 2) begin
                n_checks++; if (if1.ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready c=%0d got %b exp 0", c, if1.ready); end
            end
            if1.load = (c == 0 || c == 2);
            if1.din  = (c == 0) ? s[31:0] : 32'hFFFF_FFFF;
            tick();
        end
        if1.load = 1'b0;
        n_checks++; if (if1.word_done !== 1'b1) begin n_fail++; $display("FAIL ovf_word_done got %b exp 1", if1.word_done); end
        tick();
        n_checks++; if (if1.busy !== 1'b0)      begin n_fail++; $display("FAIL ovf_busy_after got %b exp 0", if1.busy); end
        n_checks++; if (if1.ready !== 1'b1)     begin n_fail++; $display("FAIL ovf_ready_after got %b exp 1", if1.ready); end
        n_checks++; if (if1.overflow !== 1'b1)  begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", if1.overflow); end
    endtask

    // Synchronous reset at bit 10 aborts the word without word_done.
    task automatic test_reset_mid_word();
        logic [31:0] v;
        int          n_done;
        int          n_high;
        n_done = 0;
        n_high = 0;
        if1.load = 1'b1; if1.din = 32'hFFFF_FFFF;
        tick();
        if1.load = 1'b0;
        tick();
        for (int c = 0; c < 10; c++) tick();
        n_checks++; if (if1.sout !== 1'b1) begin n_fail++; $display("FAIL rmw_sout_bit10 got %b exp 1", if1.sout); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (if1.sout !== 1'b0)      begin n_fail++; $display("FAIL rmw_sout got %b exp 0", if1.sout); end
        n_checks++; if (if1.busy !== 1'b0)      begin n_fail++; $display("FAIL rmw_busy got %b exp 0", if1.busy); end
        n_checks++; if (if1.ready !== 1'b1)     begin n_fail++; $display("FAIL rmw_ready got %b exp 1", if1.ready); end
        n_checks++; if (if1.overflow !== 1'b0)  begin n_fail++; $display("FAIL rmw_overflow got %b exp 0", if1.overflow); end
        n_checks++; if (if1.frame !== 1'b0 || if1.bit_stb !== 1'b0) begin n_fail++; $display("FAIL rmw_strobes got %b%b exp 00", if1.frame, if1.bit_stb); end
        for (int c = 0; c < 40; c++) begin
            if (if1.word_done === 1'b1) n_done++;
            if (if1.sout === 1'b1) n_high++;
            tick();
        end
        n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL rmw_no_word_done got %0d exp 0", n_done); end
        n_checks++; if (n_high !== 0) begin n_fail++; $display("FAIL rmw_sout_quiet got %0d exp 0", n_high); end
        v = 32'h0000_0003;
        if1.load = 1'b1; if1.din = v;
        tick();
        if1.load = 1'b0;
        tick();
        for (int c = 0; c < 32; c++) begin
            n_checks++; if (if1.sout !== v[31-c]) begin n_fail++; $display("FAIL rmw_reload_sout c=%0d got %b exp %b", c, if1.sout, v[31-c]); end
            tick();
        end
        n_checks++; if (if1.word_done !== 1'b1) begin n_fail++; $display("FAIL rmw_reload_word_done got %b exp 1", if1.word_done); end
        tick();
    endtask

    // LSB first with CLK_DIV=2.
    task automatic test_lsb_first();
        logic [31:0] v;
        v = 32'h0000_0001;
        if2.load = 1'b1; if2.din = v;
        tick();
        if2.load = 1'b0;
        tick();
        for (int c = 0; c < 64; c++) begin
            n_checks++; if (if2.sout !== v[c/2])            begin n_fail++; $display("FAIL lsb_sout c=%0d got %b exp %b", c, if2.sout, v[c/2]); end
            n_checks++; if (if2.bit_stb !== ((c % 2) == 0)) begin n_fail++; $display("FAIL lsb_bit_stb c=%0d got %b exp %b", c, if2.bit_stb, ((c % 2) == 0)); end
            n_checks++; if (if2.frame !== (c < 2))          begin n_fail++; $display("FAIL lsb_frame c=%0d got %b exp %b", c, if2.frame, (c < 2)); end
            tick();
        end
        n_checks++; if (if2.word_done !== 1'b1) begin n_fail++; $display("FAIL lsb_word_done got %b exp 1", if2.word_done); end
        n_checks++; if (if2.busy !== 1'b0)      begin n_fail++; $display("FAIL lsb_busy_end got %b exp 0", if2.busy); end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        if1.load = 1'b0; if1.din = 32'h0000_0000;
        if4.load = 1'b0; if4.din = 32'h0000_0000;
        if2.load = 1'b0; if2.din = 32'h0000_0000;
        test_reset();
        test_single();
        test_clkdiv4();
        test_back_to_back();
        test_overflow();
        test_reset_mid_word();
        test_lsb_first();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
